// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: freeze/bubble/flush control, three-source feedback, stall statistics and memory-wait watchdog
module pipeline_stall_controller #(
  parameter int CNT_WIDTH   = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 id_three_source,
  input  logic                 mem_wait,
  input  logic                 branch_taken,
  output logic                 freeze_if,
  output logic                 freeze_id,
  output logic                 freeze_exe,
  output logic                 freeze_mem,
  output logic                 bubble_exe,
  output logic                 flush_if_id,
  output logic [CNT_WIDTH-1:0] hazard_stall_cnt,
  output logic [CNT_WIDTH-1:0] mem_stall_cnt,
  output logic                 mem_timeout_err
);
  typedef enum logic [1:0] {RUN, THREE_SRC, MEM_HOLD} state_t;
  localparam int WD_W = ($clog2(MEM_TIMEOUT + 1) < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(MEM_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MEM_TIMEOUT - 1);
  state_t state, ret_state, eff_state;
  logic [WD_W-1:0] wd;
  always_comb begin
    eff_state   = (state == MEM_HOLD) ? ret_state : state;
    freeze_mem  = !rst && mem_wait;
    flush_if_id = !rst && !mem_wait && branch_taken;
    bubble_exe  = !rst && !mem_wait && (branch_taken || hazard_detected);
    freeze_if   = !rst && (mem_wait || (!branch_taken && hazard_detected));
    freeze_id   = freeze_if;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RUN;
      ret_state        <= RUN;
      freeze_exe       <= 1'b0;
      hazard_stall_cnt <= '0;
      mem_stall_cnt    <= '0;
      wd               <= '0;
      mem_timeout_err  <= 1'b0;
    end else begin
      if (mem_wait) begin
        state <= MEM_HOLD;
        if (state != MEM_HOLD) ret_state <= state;
      end else if (branch_taken) begin
        state      <= RUN;
        freeze_exe <= 1'b0;
      end else if (hazard_detected) begin
        if (eff_state == RUN && id_three_source) begin
          state      <= THREE_SRC;
          freeze_exe <= 1'b1;
        end else state <= eff_state;
      end else begin
        state      <= RUN;
        freeze_exe <= 1'b0;
      end
      if (bubble_exe && !branch_taken && !(&hazard_stall_cnt)) hazard_stall_cnt <= hazard_stall_cnt + 1'b1;
      if (mem_wait && !(&mem_stall_cnt)) mem_stall_cnt <= mem_stall_cnt + 1'b1;
      wd <= mem_wait ? ((wd == WD_MAX) ? wd : wd + 1'b1) : '0;
      if (mem_wait && wd >= WD_LAST) mem_timeout_err <= 1'b1;
    end
  end
endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard-detect flag from the ID stage, the memory-stage wait signal and the EXE-stage branch signal.
- Drives every pipeline-register control: freeze, bubble and flush.
- Generates the registered freeze_exe feedback that the hazard detector uses to let a three-source instruction through after one stall cycle.
- Keeps saturating stall statistics and a memory-wait watchdog.

Parameters:
- CNT_WIDTH, 16, width of each stall counter (saturating).
- MEM_TIMEOUT, 255, number of consecutive mem_wait cycles after which mem_timeout_err is raised.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- hazard_detected  input  1  from ID-stage hazard detector
- id_three_source  input  1  ID instruction needs third register read (e.g. register-shifted operand / MLA)
- mem_wait  input  1  memory stage not ready (SRAM/cache busy); whole pipeline must hold
- branch_taken  input  1  EXE stage resolved a taken branch this cycle
- freeze_if  output  1  hold PC and IF/ID register
- freeze_id  output  1  hold ID/EXE register contents
- freeze_exe  output  1  registered; third-operand read in progress, fed back to hazard detector
- freeze_mem  output  1  hold EXE/MEM and MEM/WB registers
- bubble_exe  output  1  load NOP (all enables 0) into ID/EXE
- flush_if_id  output  1  clear IF/ID to NOP
- hazard_stall_cnt  output  CNT_WIDTH  cycles spent in data-hazard stall
- mem_stall_cnt  output  CNT_WIDTH  cycles spent in mem_wait
- mem_timeout_err  output  1  sticky, set when watchdog expires

Behaviour:
- Reset (async, rst=1):
  - state=RUN, freeze_exe=0, both counters=0, watchdog=0, mem_timeout_err=0.
  - All combinational outputs are 0 while rst=1.
- States: RUN, THREE_SRC, MEM_HOLD. Priority when several inputs assert in one cycle: mem_wait > branch_taken > hazard/three-source.
- mem_wait=1, any state:
  - freeze_if=freeze_id=freeze_mem=1; bubble_exe=0, flush_if_id=0.
  - Branch flush is deferred: branch_taken is ignored while mem_wait=1; EXE holds, so branch_taken re-asserts after release.
  - Enter or stay in MEM_HOLD; remember the state it came from.
  - freeze_exe keeps its value during the hold.
- MEM_HOLD, mem_wait=0: return to the remembered state the next cycle; outputs are evaluated as in that state in the same cycle.
- branch_taken=1, mem_wait=0:
  - flush_if_id=1, bubble_exe=1, freeze_if=freeze_id=0.
  - Overrides hazard. Next state RUN; freeze_exe cleared next edge.
- RUN, hazard_detected=1, no higher-priority event:
  - freeze_if=1, freeze_id=1, bubble_exe=1.
  - If id_three_source=1: next state THREE_SRC and freeze_exe<=1 at the edge.
  - Otherwise stay in RUN (plain data-hazard stall, repeats while the hazard persists).
- THREE_SRC:
  - freeze_exe=1 (registered). Hazard detector drops its three-source stall.
  - If hazard_detected=0: no freeze, instruction advances; next state RUN, freeze_exe<=0.
  - If hazard_detected=1 (true data hazard): stall as in RUN, remain in THREE_SRC.
- Outputs:
  - freeze_*, bubble_exe and flush_if_id are combinational from state and inputs; zero-cycle latency.
  - freeze_exe changes only on clock edges.
- hazard_stall_cnt: +1 each cycle with bubble_exe=1 and branch_taken=0.
- mem_stall_cnt: +1 each cycle with mem_wait=1.
- Both counters saturate at all-ones, with no wrap.
- Watchdog:
  - Counts consecutive mem_wait cycles; cleared when mem_wait=0.
  - On reaching MEM_TIMEOUT, mem_timeout_err<=1 (sticky until rst). Stalling continues regardless.
- Reset asserted mid-stall: all state is lost immediately; pipeline outputs are 0 on the same cycle.

Test Plan:
- rst pulse mid-MEM_HOLD -> all outputs 0 asynchronously; after release, counters=0 and state RUN.
- hazard_detected=1 for 3 cycles, id_three_source=0 -> freeze_if/freeze_id/bubble_exe high exactly 3 cycles; hazard_stall_cnt=3; freeze_exe stays 0.
- id_three_source=1 with hazard_detected=1 in cycle 0 (detector dropping it once freeze_exe=1) -> 1 bubble cycle; freeze_exe=1 in cycle 1 with no freeze; freeze_exe=0 in cycle 2.
- branch_taken=1 and hazard_detected=1 simultaneously -> flush_if_id=1, bubble_exe=1, freeze_if=0; hazard_stall_cnt unchanged.
- mem_wait=1 for 4 cycles, entered from THREE_SRC -> freeze_if/freeze_id/freeze_mem high 4 cycles; freeze_exe held at 1; resume in THREE_SRC; mem_stall_cnt=4.
- MEM_TIMEOUT=5, mem_wait held 7 cycles -> mem_timeout_err rises after the 5th cycle and stays 1 after mem_wait drops. With CNT_WIDTH=2 the counter saturates at 3.
